// File: rtl/mppc_link_pkg.sv
// mppc_link_pkg: shared constants and state type for the two-wire serial link.
package mppc_link_pkg;
    localparam int LINK_DATA_WIDTH     = 8;
    localparam int LINK_SYS_CLK_HZ     = 9_600_000;
    localparam int LINK_TIMEOUT_CYCLES = 4800;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizer with registered rising-edge pulse for an asynchronous line.
// Defining DATA_INPUT_DEGLITCH_EN adds a 3-sample majority filter after the synchronizer.
module sync_edge_detect
    import mppc_link_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic [STAGES-1:0] sync_q;
    logic              lvl;
    logic              prev_q;
    logic              rise_q;
`ifdef DATA_INPUT_DEGLITCH_EN
    logic [1:0] hist_q;
    logic       filt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_q[STAGES-1]};
            filt_q <= maj3(sync_q[STAGES-1], hist_q[0], hist_q[1]);
        end
    end
    assign lvl = filt_q;
`else
    assign lvl = sync_q[STAGES-1];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
        end
    end
    assign rise_o = rise_q;
endmodule

// File: rtl/data_input.sv
// data_input: serial link receiver, deserializes LSB-first words onto a valid/ready port.
// Defining DATA_INPUT_DEGLITCH_EN filters clockIn/dataIn with a majority vote (+2 cycles latency).
module data_input
    import mppc_link_pkg::*;
#(
    parameter int DATA_WIDTH     = LINK_DATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = LINK_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clockIn,
    input  logic                  dataIn,
    input  logic                  ready,
    input  logic                  clearOverrun,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  overrun,
    output logic                  frameError,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic                   rise;
    logic [SYNC_STAGES-1:0] dsync_q;
    logic                   dlvl;
    logic                   dbit_q;
    link_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dv_q, dv_d;
    logic                   ovr_q, ovr_d;
    logic                   ferr_q, ferr_d;
    logic                   done;
    logic                   load;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk    (CLK),
        .rst    (RST),
        .d_i    (clockIn),
        .rise_o (rise)
    );

    // dbit_q mirrors the edge-detect register so the bit lines up with rise.
`ifdef DATA_INPUT_DEGLITCH_EN
    logic [1:0] dhist_q;
    logic       dfilt_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dhist_q <= '0;
            dfilt_q <= 1'b0;
        end else begin
            dhist_q <= {dhist_q[0], dsync_q[SYNC_STAGES-1]};
            dfilt_q <= maj3(dsync_q[SYNC_STAGES-1], dhist_q[0], dhist_q[1]);
        end
    end
    assign dlvl = dfilt_q;
`else
    assign dlvl = dsync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (rise) begin
                shift_d[0] = dbit_q;
                cnt_d      = CW'(1);
                state_d    = SHIFT;
            end
        end else if (rise) begin
            shift_d[cnt_q] = dbit_q;
            cnt_d          = cnt_q + 1'b1;
            tmo_d          = '0;
            if (cnt_q == LAST_BIT) begin
                cnt_d   = '0;
                state_d = IDLE;
                done    = 1'b1;
            end
        end else if (tmo_q == TMO_LAST) begin
            ferr_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        load   = done & (~dv_q | ready);
        dv_d   = load | (dv_q & ~ready);
        dout_d = load ? shift_d : dout_q;
        ovr_d  = (done & dv_q & ~ready) | (ovr_q & ~clearOverrun);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsync_q <= '0;
            dbit_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            dsync_q <= {dsync_q[SYNC_STAGES-2:0], dataIn};
            dbit_q  <= dlvl;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dataOut    = dout_q;
    assign dataValid  = dv_q;
    assign overrun    = ovr_q;
    assign frameError = ferr_q;
    assign busy       = (state_q == SHIFT);
endmodule

// File: tb/tb_data_input.sv
// tb_data_input: random and directed serial traffic against an event-scheduled model of data_input.
module tb_data_input;
`ifdef DATA_INPUT_DEGLITCH_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif
    localparam int T        = 4800;
    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_FERR  = 2;

    typedef struct {
        int         c;
        int         k;
        logic [7:0] w;
    } ev_t;

    logic       CLK = 0, RST = 1, clockIn = 0, dataIn = 0, ready = 0, clearOverrun = 0;
    logic [7:0] dataOut;
    logic       dataValid, overrun, frameError, busy;

    int   n_chk = 0, n_fail = 0, cyc = 0, fe_cnt = 0, v_rise_cyc = -1;
    logic prev_v = 0;
    bit   rnd_en = 0;
    ev_t  ev_q[$];
    logic m_valid = 0, m_ovr = 0, m_ferr = 0, m_busy = 0, m_set = 0, m_was = 0;
    logic [7:0] m_data = 0;

    data_input dut (
        .CLK          (CLK),
        .RST          (RST),
        .clockIn      (clockIn),
        .dataIn       (dataIn),
        .ready        (ready),
        .clearOverrun (clearOverrun),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .overrun      (overrun),
        .frameError   (frameError),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int c, input int k, input logic [7:0] w);
        ev_t e;
        e.c = c;
        e.k = k;
        e.w = w;
        ev_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Word-level model: the sender schedules when each frame starts, completes or times out.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid = 0;
            m_data  = 0;
            m_ovr   = 0;
            m_ferr  = 0;
            m_busy  = 0;
            ev_q.delete();
        end else begin
            cyc++;
            m_was  = m_valid;
            m_set  = 0;
            m_ferr = 0;
            if (m_valid && ready) m_valid = 0;
            for (int i = ev_q.size() - 1; i >= 0; i--) begin
                if (ev_q[i].c == cyc) begin
                    if (ev_q[i].k == EV_START) m_busy = 1;
                    else if (ev_q[i].k == EV_FERR) begin
                        m_busy = 0;
                        m_ferr = 1;
                    end else begin
                        m_busy = 0;
                        if (!m_was || ready) begin
                            m_valid = 1;
                            m_data  = ev_q[i].w;
                        end else m_set = 1;
                    end
                    ev_q.delete(i);
                end
            end
            m_ovr = m_set || (m_ovr && !clearOverrun);
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check("valid", dataValid, m_valid);
            check("data", dataOut, m_data);
            check("overrun", overrun, m_ovr);
            check("frameError", frameError, m_ferr);
            check("busy", busy, m_busy);
            if (frameError) fe_cnt++;
            if (dataValid && !prev_v) v_rise_cyc = cyc;
            prev_v = dataValid;
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rnd_en) begin
            ready        = 1'($urandom_range(0, 1));
            clearOverrun = ($urandom_range(0, 7) == 0);
        end
    end

    task automatic send_bits(input logic [7:0] w, input int n, input int half, input bit ack,
                             input bit glitch, output int last_c);
        last_c = cyc;
        for (int i = 0; i < n; i++) begin
            clockIn = 0;
            dataIn  = w[i];
            if (glitch) begin
                tick(2);
                clockIn = 1;
                tick(1);
                clockIn = 0;
                tick(half - 3);
            end else tick(half);
            clockIn = 1;
            last_c  = cyc;
            if (i == 0) push_ev(cyc + LAT, EV_START, 8'h00);
            if (i == n - 1) begin
                if (n == 8) push_ev(cyc + LAT, EV_DONE, w);
                else push_ev(cyc + LAT + T, EV_FERR, w);
            end
            if (ack && i == n - 1) begin
                tick(LAT - 1);
                ready = 1;
                tick(1);
                ready = 0;
                tick(half - LAT);
            end else tick(half);
        end
        clockIn = 0;
    endtask

    initial begin
        int         lc;
        logic [7:0] w;
        tick(3);
        check("rst_data", dataOut, 0);
        check("rst_valid", dataValid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_ferr", frameError, 0);
        check("rst_busy", busy, 0);
        RST = 0;
        tick(5);

        ready = 1;
        send_bits(8'hA5, 8, 5, 0, 0, lc);
        tick(10);
        check("t1_data", dataOut, 8'hA5);
        check("t1_pulse_done", dataValid, 0);
        check("t1_latency", v_rise_cyc - lc, LAT);
        check("t1_ovr", overrun, 0);
        check("t1_no_ferr", fe_cnt, 0);

        ready = 0;
        send_bits(8'h3C, 8, 5, 0, 0, lc);
        send_bits(8'hC3, 8, 5, 0, 0, lc);
        tick(10);
        check("t2_data", dataOut, 8'h3C);
        check("t2_valid", dataValid, 1);
        check("t2_ovr", overrun, 1);
        clearOverrun = 1;
        tick(1);
        clearOverrun = 0;
        tick(1);
        check("t2_ovr_clr", overrun, 0);
        check("t2_hold", dataValid, 1);
        ready = 1;
        tick(1);
        ready = 0;
        tick(2);
        check("t2_drain", dataValid, 0);

        ready = 1;
        send_bits(8'h1F, 5, 5, 0, 0, lc);
        for (int i = 0; i < 6000 && !frameError; i++) tick(1);
        check("t3_ferr", frameError, 1);
        check("t3_busy", busy, 0);
        check("t3_ferr_time", cyc - lc, LAT + T);
        tick(3);
        check("t3_ferr_once", fe_cnt, 1);
        send_bits(8'h81, 8, 5, 0, 0, lc);
        tick(10);
        check("t3_data", dataOut, 8'h81);

        ready = 0;
        send_bits(8'h55, 8, 5, 0, 0, lc);
        tick(10);
        check("t4_held", dataValid, 1);
        send_bits(8'hAA, 4, 5, 0, 0, lc);
        tick(2);
        #2 RST = 1;
        #1;
        check("t4_rst_data", dataOut, 0);
        check("t4_rst_valid", dataValid, 0);
        check("t4_rst_ovr", overrun, 0);
        check("t4_rst_ferr", frameError, 0);
        check("t4_rst_busy", busy, 0);
        @(posedge CLK);
        #1 RST = 0;
        tick(3);
        ready = 1;
        send_bits(8'hFF, 8, 5, 0, 0, lc);
        tick(10);
        check("t4_data", dataOut, 8'hFF);

        ready = 0;
        send_bits(8'h34, 8, 8, 0, 0, lc);
        tick(5);
        send_bits(8'h12, 8, 8, 1, 0, lc);
        check("t5_data", dataOut, 8'h12);
        check("t5_valid", dataValid, 1);
        check("t5_ovr", overrun, 0);
        ready = 1;
        tick(2);
`ifdef DATA_INPUT_DEGLITCH_EN
        send_bits(8'h5A, 8, 8, 0, 1, lc);
        tick(10);
        check("dg_data", dataOut, 8'h5A);
        check("dg_busy", busy, 0);
`endif

        rnd_en = 1;
        for (int n = 0; n < 25; n++) begin
            w = 8'($urandom);
            send_bits(w, 8, $urandom_range(LAT + 1, 12), 0, 0, lc);
            tick($urandom_range(0, 20));
        end
        rnd_en       = 0;
        clearOverrun = 0;
        ready        = 1;
        tick(10);
        check("rnd_drain", dataValid, 0);
        check("rnd_events_left", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
